// File: rtl/subleq_engine_if.sv
// ============================================================================
// Module   : subleq_engine_if
// Purpose  : Single-port memory request/ack bus between the engine and memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface subleq_engine_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/subleq_engine.sv
// ============================================================================
// Module   : subleq_engine
// Purpose  : Multi-cycle SUBLEQ/SUBNEG processor over a request/ack memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module subleq_engine #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int BRANCH_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  subleq_engine_if.master   mem,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr_count
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_B = 4'd2,
    S_FETCH_C = 4'd3,
    S_READ_A  = 4'd4,
    S_READ_B  = 4'd5,
    S_EXEC    = 4'd6,
    S_WRITE   = 4'd7,
    S_HALTED  = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] c_halt_pc = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc, r_a, r_b, r_c;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_result;
  logic [31:0]       r_count;
  logic              r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0] w_diff;
  logic              w_taken;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_diff    = r_op_b - r_op_a;
  // Branch decision uses the result registered in EXEC, held through WRITE.
  assign w_taken   = (BRANCH_MODE == 0) ? (r_result[DATA_W-1] || (r_result == '0))
                                        : r_result[DATA_W-1];
  assign w_xfer    = r_req && mem.mem_ack;
  assign w_pc_next = w_taken ? r_c : r_pc + ADDR_W'(3);
  assign w_rd_addr = mem.mem_rdata[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            r_pc    <= start_pc;
            r_count <= '0;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= start_pc;
            r_wdata <= '0;
            r_state <= S_FETCH_A;
          end
        end
        S_FETCH_A: if (w_xfer) begin
          r_a     <= w_rd_addr;
          r_addr  <= r_pc + ADDR_W'(1);
          r_state <= S_FETCH_B;
        end
        S_FETCH_B: if (w_xfer) begin
          r_b     <= w_rd_addr;
          r_addr  <= r_pc + ADDR_W'(2);
          r_state <= S_FETCH_C;
        end
        S_FETCH_C: if (w_xfer) begin
          r_c     <= w_rd_addr;
          r_addr  <= r_a;
          r_state <= S_READ_A;
        end
        S_READ_A: if (w_xfer) begin
          r_op_a  <= mem.mem_rdata;
          r_addr  <= r_b;
          r_state <= S_READ_B;
        end
        S_READ_B: if (w_xfer) begin
          r_op_b  <= mem.mem_rdata;
          r_req   <= 1'b0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_diff;
          r_req    <= 1'b1;
          r_we     <= 1'b1;
          r_addr   <= r_b;
          r_wdata  <= w_diff;
          r_state  <= S_WRITE;
        end
        S_WRITE: if (w_xfer) begin
          r_count <= r_count + 32'd1;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_pc    <= w_pc_next;
          // A taken branch to the all-ones address is the halt idiom.
          if (w_taken && (r_c == c_halt_pc)) begin
            r_req   <= 1'b0;
            r_state <= S_HALTED;
          end else begin
            r_addr  <= w_pc_next;
            r_state <= S_FETCH_A;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted      = (r_state == S_HALTED);
  assign pc          = r_pc;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_subleq_engine.sv
// ============================================================================
// Module   : tb_subleq_engine
// Purpose  : Directed self-checking bench for subleq_engine (both branch modes).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_subleq_engine;
  localparam int DW = 64;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;

  always #5 clk = ~clk;

  subleq_engine_if #(.DATA_W(DW), .ADDR_W(AW)) m0 ();
  subleq_engine_if #(.DATA_W(DW), .ADDR_W(AW)) m1 ();

  logic          busy0, halted0, busy1, halted1;
  logic [AW-1:0] pc0, pc1;
  logic [31:0]   cnt0, cnt1;

  subleq_engine #(.DATA_W(DW), .ADDR_W(AW), .BRANCH_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .mem(m0),
    .busy(busy0), .halted(halted0), .pc(pc0), .instr_count(cnt0)
  );

  subleq_engine #(.DATA_W(DW), .ADDR_W(AW), .BRANCH_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .mem(m1),
    .busy(busy1), .halted(halted1), .pc(pc1), .instr_count(cnt1)
  );

  // Memory models: m0 has programmable wait states, m1 is always zero-wait.
  logic [DW-1:0] mem0 [0:65535];
  logic [DW-1:0] mem1 [0:65535];
  int            wait_cycles = 0;
  int            wcnt = 0;
  logic          block_write = 1'b0;
  logic          ld_en = 1'b0;
  logic          clr_mem = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  assign m0.mem_ack   = m0.mem_req && (wcnt >= wait_cycles) && !(block_write && m0.mem_we);
  assign m0.mem_rdata = mem0[m0.mem_addr];
  assign m1.mem_ack   = m1.mem_req;
  assign m1.mem_rdata = mem1[m1.mem_addr];

  always @(posedge clk) begin
    if (rst || !m0.mem_req || m0.mem_ack) wcnt <= 0;
    else                                  wcnt <= wcnt + 1;
    if (clr_mem) begin
      for (int i = 0; i < 65536; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else if (ld_en) begin
      mem0[ld_addr] <= ld_data;
      mem1[ld_addr] <= ld_data;
    end else begin
      if (m0.mem_req && m0.mem_ack && m0.mem_we) mem0[m0.mem_addr] <= m0.mem_wdata;
      if (m1.mem_req && m1.mem_ack && m1.mem_we) mem1[m1.mem_addr] <= m1.mem_wdata;
    end
  end

  // Request fields must not move while a transfer is waiting for ack.
  logic          pend = 1'b0;
  logic          s_we = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  int            stab_err = 0;

  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else     pend <= m0.mem_req && !m0.mem_ack;
    s_we    <= m0.mem_we;
    s_addr  <= m0.mem_addr;
    s_wdata <= m0.mem_wdata;
  end

  always @(negedge clk) begin
    if (pend && (!m0.mem_req || m0.mem_we != s_we || m0.mem_addr != s_addr ||
                 m0.mem_wdata != s_wdata))
      stab_err <= stab_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick(1);
    ld_en   = 1'b0;
  endtask

  task automatic hold_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick(2);
  endtask

  task automatic go(input logic [AW-1:0] spc);
    rst      = 1'b0;
    start_pc = spc;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] c;
    logic [DW-1:0] exp_res;
    logic [AW-1:0] exp_pc;
    logic          exp_halt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'd5, 64'd7, 16'd3, 64'd2, 16'd3, 1'b0};
    vecs[1] = '{64'd7, 64'd5, 16'd20, 64'hFFFF_FFFF_FFFF_FFFE, 16'd20, 1'b0};
    vecs[2] = '{64'd9, 64'd9, 16'd40, 64'd0, 16'd40, 1'b0};
    vecs[3] = '{64'd1, 64'd0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd0, 16'd50, 64'h8000_0000_0000_0000, 16'd50, 1'b0};
    vecs[5] = '{64'd1, 64'h8000_0000_0000_0000, 16'd60, 64'h7FFF_FFFF_FFFF_FFFF, 16'd3, 1'b0};
    vecs[6] = '{64'd0, 64'd0, 16'hFFFF, 64'd0, 16'hFFFF, 1'b1};

    clr_mem = 1'b1;
    tick(1);
    clr_mem = 1'b0;
    hold_reset();

    chk("rst_mem_req", 64'(m0.mem_req), 64'd0);
    chk("rst_mem_we", 64'(m0.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(m0.mem_addr), 64'd0);
    chk("rst_mem_wdata", m0.mem_wdata, 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_halted", 64'(halted0), 64'd0);
    chk("rst_pc", 64'(pc0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);

    // One instruction per vector, zero-wait: retires on the 7th edge after start.
    for (int i = 0; i < 7; i++) begin
      hold_reset();
      load(16'd0, 64'd10);
      load(16'd1, 64'd11);
      load(16'd2, 64'(vecs[i].c));
      load(16'd10, vecs[i].op_a);
      load(16'd11, vecs[i].op_b);
      go(16'd0);
      tick(6);
      chk($sformatf("v%0d_count_6cyc", i), 64'(cnt0), 64'd0);
      chk($sformatf("v%0d_busy_6cyc", i), 64'(busy0), 64'd1);
      tick(1);
      chk($sformatf("v%0d_result", i), mem0[11], vecs[i].exp_res);
      chk($sformatf("v%0d_pc", i), 64'(pc0), 64'(vecs[i].exp_pc));
      chk($sformatf("v%0d_halted", i), 64'(halted0), 64'(vecs[i].exp_halt));
      chk($sformatf("v%0d_busy", i), 64'(busy0), 64'(!vecs[i].exp_halt));
      chk($sformatf("v%0d_count", i), 64'(cnt0), 64'd1);
    end

    // Two-instruction program: halts in mode 0, falls through in mode 1.
    hold_reset();
    load(16'd0, 64'd10);
    load(16'd1, 64'd11);
    load(16'd2, 64'd3);
    load(16'd3, 64'd12);
    load(16'd4, 64'd12);
    load(16'd5, 64'hFFFF);
    load(16'd10, 64'd5);
    load(16'd11, 64'd7);
    load(16'd12, 64'd9);
    go(16'd0);
    tick(14);
    chk("prog_m0_mem11", mem0[11], 64'd2);
    chk("prog_m0_mem12", mem0[12], 64'd0);
    chk("prog_m0_halted", 64'(halted0), 64'd1);
    chk("prog_m0_busy", 64'(busy0), 64'd0);
    chk("prog_m0_pc", 64'(pc0), 64'hFFFF);
    chk("prog_m0_count", 64'(cnt0), 64'd2);
    chk("prog_m1_mem12", mem1[12], 64'd0);
    chk("prog_m1_halted", 64'(halted1), 64'd0);
    chk("prog_m1_pc", 64'(pc1), 64'd6);
    chk("prog_m1_count", 64'(cnt1), 64'd2);
    tick(3);
    chk("halt_holds", 64'({halted0, m0.mem_req}), 64'b10);

    // Three wait cycles per transfer: 6 memory states x 4 cycles + EXEC.
    hold_reset();
    load(16'd11, 64'd7);
    wait_cycles = 3;
    go(16'd0);
    begin
      int n;
      n = 0;
      while (cnt0 != 32'd1 && n < 200) begin
        tick(1);
        n++;
      end
      chk("wait_cycles_per_instr", 64'(n), 64'd25);
    end
    chk("wait_result", mem0[11], 64'd2);
    chk("wait_pc", 64'(pc0), 64'd3);

    // Program counter wraps across the top of the address space.
    hold_reset();
    wait_cycles = 0;
    load(16'hFFFE, 64'd10);
    load(16'hFFFF, 64'd11);
    load(16'h0000, 64'd3);
    load(16'd10, 64'd5);
    load(16'd11, 64'd7);
    go(16'hFFFE);
    chk("wrap_fetch_a", 64'(m0.mem_addr), 64'hFFFE);
    tick(1);
    chk("wrap_fetch_b", 64'(m0.mem_addr), 64'hFFFF);
    tick(1);
    chk("wrap_fetch_c", 64'(m0.mem_addr), 64'h0000);
    tick(5);
    chk("wrap_pc", 64'(pc0), 64'h0001);
    chk("wrap_count", 64'(cnt0), 64'd1);

    // Start while busy is ignored; reset abandons a stalled write.
    hold_reset();
    load(16'd0, 64'd10);
    load(16'd1, 64'd11);
    load(16'd2, 64'd3);
    load(16'd11, 64'd7);
    block_write = 1'b1;
    go(16'd0);
    start_pc = 16'h0040;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    chk("busy_start_pc", 64'(pc0), 64'd0);
    chk("busy_start_addr", 64'(m0.mem_addr), 64'd1);
    begin
      int n;
      n = 0;
      while (!(m0.mem_req && m0.mem_we) && n < 50) begin
        tick(1);
        n++;
      end
      chk("reach_write", 64'(m0.mem_req && m0.mem_we), 64'd1);
    end
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_abort_req", 64'(m0.mem_req), 64'd0);
    chk("rst_abort_busy", 64'(busy0), 64'd0);
    chk("rst_abort_halted", 64'(halted0), 64'd0);
    rst = 1'b0;
    block_write = 1'b0;
    tick(3);
    chk("rst_abort_mem", mem0[11], 64'd7);
    chk("rst_abort_count", 64'(cnt0), 64'd0);
    chk("idle_no_req", 64'(m0.mem_req), 64'd0);

    chk("req_stability", 64'(stab_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
